// File: rtl/link_status_led.sv
// link_status_led: qualifies the activity indicator into a link status
// and drives the board LED plus a sticky loss history for readout.
module link_status_led #(
  parameter int QUAL_CYCLES = 1000,
  parameter int BLINK_HALF  = 25_000_000,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             active_in,
  input  logic             clear,
  output logic             led,
  output logic [1:0]       state_o,
  output logic             lost_flag,
  output logic [CNT_W-1:0] lost_cnt
);

  localparam int QW = $clog2(QUAL_CYCLES + 1);
  localparam int BW = $clog2(BLINK_HALF + 1);
  localparam logic [QW-1:0] QLAST = QW'(QUAL_CYCLES - 1);
  localparam logic [BW-1:0] BLAST = BW'(BLINK_HALF - 1);

  typedef enum logic [1:0] {
    NO_SIG  = 2'd0,
    QUALIFY = 2'd1,
    PRESENT = 2'd2,
    LOST    = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [QW-1:0]    qual_q, qual_d;
  logic [BW-1:0]    blink_q, blink_d;
  logic             ph_q, ph_d;
  logic             from_lost_q, from_lost_d;
  logic             flag_q, flag_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             led_q, led_d;
  logic             loss_evt;
  logic [CNT_W-1:0] cnt_base;

  // A single qualifying cycle skips QUALIFY entirely.
  state_t qual_entry;
  assign qual_entry = (QUAL_CYCLES == 1) ? PRESENT : QUALIFY;

  // State register with every internal counter and all registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= NO_SIG;
      qual_q      <= '0;
      blink_q     <= '0;
      ph_q        <= 1'b0;
      from_lost_q <= 1'b0;
      flag_q      <= 1'b0;
      cnt_q       <= '0;
      led_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      qual_q      <= qual_d;
      blink_q     <= blink_d;
      ph_q        <= ph_d;
      from_lost_q <= from_lost_d;
      flag_q      <= flag_d;
      cnt_q       <= cnt_d;
      led_q       <= led_d;
    end
  end

  // Next-state: qualification, loss detection and blink timebase.
  always_comb begin
    state_d     = state_q;
    qual_d      = qual_q;
    blink_d     = blink_q;
    ph_d        = ph_q;
    from_lost_d = from_lost_q;
    loss_evt    = 1'b0;
    unique case (state_q)
      NO_SIG: begin
        if (active_in) begin
          state_d     = qual_entry;
          qual_d      = QW'(1);
          from_lost_d = 1'b0;
        end
      end
      QUALIFY: begin
        if (clear) from_lost_d = 1'b0;
        if (active_in) begin
          if (qual_q == QLAST) state_d = PRESENT;
          else qual_d = qual_q + QW'(1);
        end else begin
          state_d = (from_lost_q && !clear) ? LOST : NO_SIG;
          blink_d = '0;
          ph_d    = 1'b0;
        end
      end
      PRESENT: begin
        if (!active_in) begin
          state_d  = LOST;
          blink_d  = '0;
          ph_d     = 1'b0;
          loss_evt = 1'b1;
        end
      end
      LOST: begin
        if (active_in) begin
          state_d     = qual_entry;
          qual_d      = QW'(1);
          from_lost_d = !clear;
        end else if (clear) begin
          state_d = NO_SIG;
        end else if (blink_q == BLAST) begin
          blink_d = '0;
          ph_d    = ~ph_q;
        end else begin
          blink_d = blink_q + BW'(1);
        end
      end
    endcase
  end

  // Outputs: clear wipes history before a same-edge loss is recorded.
  always_comb begin
    cnt_base = clear ? '0 : cnt_q;
    flag_d   = clear ? 1'b0 : flag_q;
    cnt_d    = cnt_base;
    if (loss_evt) begin
      flag_d = 1'b1;
      if (cnt_base != {CNT_W{1'b1}}) cnt_d = cnt_base + CNT_W'(1);
    end
    unique case (state_d)
      PRESENT: led_d = 1'b1;
      LOST:    led_d = ph_d;
      default: led_d = 1'b0;
    endcase
  end

  assign led       = led_q;
  assign state_o   = state_q;
  assign lost_flag = flag_q;
  assign lost_cnt  = cnt_q;

endmodule

// File: tb/tb_link_status_led.sv
// tb_link_status_led: directed plan checks plus randomized run
// against a behavioural model of the link status rules.
module tb_link_status_led;

  localparam int QC = 4;
  localparam int BH = 3;
  localparam int CW = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          resetn;
  logic          active_in;
  logic          clear;
  logic          led;
  logic [1:0]    state_o;
  logic          lost_flag;
  logic [CW-1:0] lost_cnt;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  link_status_led #(
    .QUAL_CYCLES(QC),
    .BLINK_HALF (BH),
    .CNT_W      (CW)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .active_in(active_in),
    .clear    (clear),
    .led      (led),
    .state_o  (state_o),
    .lost_flag(lost_flag),
    .lost_cnt (lost_cnt)
  );

  always #5 clk = ~clk;

  // Model: status plus run length and time spent lost.
  int m_st;
  int m_run;
  bit m_fl;
  int m_t;
  bit m_flag;
  int m_cnt;

  function automatic int m_led();
    if (m_st == 2) return 1;
    if (m_st == 3) return (m_t / BH) % 2;
    return 0;
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_st = 0; m_run = 0; m_fl = 0;
      m_t = 0; m_flag = 0; m_cnt = 0;
    end else begin
      if (clear) begin
        m_flag = 0;
        m_cnt  = 0;
      end
      case (m_st)
        0: if (active_in) begin
          m_run = 1; m_fl = 0;
          m_st = (m_run >= QC) ? 2 : 1;
        end
        1: begin
          if (clear) m_fl = 0;
          if (active_in) begin
            m_run++;
            if (m_run >= QC) m_st = 2;
          end else begin
            m_st = m_fl ? 3 : 0;
            m_t  = 0;
          end
        end
        2: if (!active_in) begin
          m_st = 3; m_t = 0; m_flag = 1;
          m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
        end
        default: begin
          if (active_in) begin
            m_run = 1; m_fl = !clear;
            m_st = (m_run >= QC) ? 2 : 1;
          end else if (clear) begin
            m_st = 0;
          end else begin
            m_t++;
          end
        end
      endcase
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (cmp_on) begin
      checks++;
      if (int'(state_o) != m_st || int'(led) != m_led() ||
          lost_flag != m_flag || int'(lost_cnt) != m_cnt) begin
        errors++;
        $display("FAIL model t=%0t st=%0d/%0d led=%0d/%0d flag=%0d/%0d cnt=%0d/%0d",
                 $time, state_o, m_st, led, m_led(), lost_flag, m_flag,
                 lost_cnt, m_cnt);
      end
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int blink_exp [6] = '{0, 0, 1, 1, 1, 0};
  int sat_exp   [4] = '{1, 2, 3, 3};

  initial begin
    resetn = 1'b0; active_in = 1'b0; clear = 1'b0;
    #12;
    chk("rst_state", int'(state_o), 0);
    chk("rst_led", int'(led), 0);
    chk("rst_flag", int'(lost_flag), 0);
    chk("rst_cnt", int'(lost_cnt), 0);
    cmp_on = 1'b1;
    resetn = 1'b1;

    active_in = 1'b1;
    tick(); chk("q1_state", int'(state_o), 1);
    chk("q1_led", int'(led), 0);
    tick(); chk("q2_led", int'(led), 0);
    tick(); chk("q3_led", int'(led), 0);
    tick(); chk("q4_state", int'(state_o), 2);
    chk("q4_led", int'(led), 1);

    active_in = 1'b0;
    tick(); chk("loss_state", int'(state_o), 3);
    chk("loss_flag", int'(lost_flag), 1);
    chk("loss_cnt", int'(lost_cnt), 1);
    chk("blink0", int'(led), 0);
    for (int i = 0; i < 6; i++) begin
      tick(); chk($sformatf("blink%0d", i + 1), int'(led), blink_exp[i]);
    end

    clear = 1'b1;
    tick(); clear = 1'b0;
    chk("clr_flag", int'(lost_flag), 0);
    chk("clr_cnt", int'(lost_cnt), 0);
    chk("clr_state", int'(state_o), 0);
    chk("clr_led", int'(led), 0);

    active_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); chk("fq_led", int'(led), 0);
    end
    active_in = 1'b0;
    tick(); chk("fq_state", int'(state_o), 0);
    chk("fq_led_end", int'(led), 0);
    chk("fq_flag", int'(lost_flag), 0);

    for (int k = 0; k < 4; k++) begin
      active_in = 1'b1;
      repeat (4) tick();
      chk("sat_present", int'(state_o), 2);
      active_in = 1'b0;
      tick(); chk($sformatf("sat_cnt%0d", k), int'(lost_cnt), sat_exp[k]);
      chk("sat_flag", int'(lost_flag), 1);
    end

    active_in = 1'b1;
    repeat (4) tick();
    active_in = 1'b0; clear = 1'b1;
    tick(); clear = 1'b0;
    chk("cl_loss_cnt", int'(lost_cnt), 1);
    chk("cl_loss_flag", int'(lost_flag), 1);
    chk("cl_loss_state", int'(state_o), 3);

    active_in = 1'b1;
    repeat (4) tick();
    active_in = 1'b0;
    tick(); tick(); tick(); tick();
    chk("ar_pre_cnt", int'(lost_cnt), 2);
    chk("ar_pre_led", int'(led), 1);
    #2 resetn = 1'b0;
    #1;
    chk("ar_led", int'(led), 0);
    chk("ar_flag", int'(lost_flag), 0);
    chk("ar_cnt", int'(lost_cnt), 0);
    chk("ar_state", int'(state_o), 0);
    @(posedge clk); #1;
    resetn = 1'b1; active_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); chk("ar_rq_state", int'(state_o), 1);
    end
    tick(); chk("ar_rq_present", int'(state_o), 2);

    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(999) < 3) begin
        resetn = 1'b0;
        #1 resetn = 1'b1;
      end
      if ($urandom_range(99) < 18) active_in = ~active_in;
      clear = ($urandom_range(99) < 4);
      tick();
    end
    clear = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
